multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Control FSM that sequences a multicycle RV32I datapath sharing one unified instruction/data memory. Decodes op/funct3/funct7b5 and drives all datapath selects, write enables and ALUControl, one FSM state per clock. Stalls on a memory ready handshake, counts retired instructions and traps on illegal opcodes. Sits beside the datapath inside the multicycle core top.

Parameters:
CNT_W, 32, width of retired-instruction counter instret.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
op  input  7  Instr[6:0] from instruction register.
funct3  input  3  Instr[14:12].
funct7b5  input  1  Instr[30].
Zero  input  1  ALU zero flag.
N  input  1  ALU negative flag (used only with feature).
V  input  1  ALU overflow flag (used only with feature).
mem_ready  input  1  unified memory completes the current access this cycle.
PCWrite  output  1  PC register load enable.
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
MemWrite  output  1  memory write strobe.
IRWrite  output  1  instruction register and OldPC load enable.
ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = A register.
ALUSrcB  output  2  00 = WriteData register, 01 = ImmExt, 10 = constant 4.
ImmSrc  output  2  00 = I, 01 = S, 10 = B, 11 = J.
RegWrite  output  1  register file write enable.
ALUControl  output  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 sra, 1000 srl.
trap  output  1  illegal opcode seen; sticky.
instret  output  CNT_W  retired-instruction count.

Behaviour:
- Reset asserted: state = FETCH; instret = 0; trap = 0. All enables (PCWrite, IRWrite, MemWrite, RegWrite) are 0 while reset is low, including when reset lands mid-instruction.
- Moore outputs per state. Only PCWrite in BEQ and the mem_ready gating are conditional.
- ImmSrc is decoded combinationally from op in every state:
  - lw, I-ALU: 00
  - sw: 01
  - branch: 10
  - jal: 11
  - other opcodes: 00
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite = PCWrite = mem_ready.
  - Stay in FETCH while mem_ready=0; otherwise go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (computes branch/jal target into ALUOut). Next state by op:
  - 0000011 / 0100011: MEMADR
  - 0110011: EXECR
  - 0010011: EXECI
  - 1100011: BRANCH
  - 1101111: JAL
  - otherwise: ERROR
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next: MEMREAD if op=lw, else MEMWR.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready. Exit to FETCH in the cycle mem_ready=1.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl from funct3/funct7b5. Sub/sra selected by funct7b5; sub only with op[5]=1. Next: ALUWB.
- EXECI: same as EXECR but ALUSrcB=01; funct3=000 is always add. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 (PC <- target). Next: ALUWB, which writes PC+4 to rd.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - funct3 000 (beq) / 001 (bne): PCWrite = Zero ^ funct3[0].
  - Other funct3 values: PCWrite=0, no trap.
  - Next: FETCH.
- ERROR: all enables 0, trap=1. Stay until reset.
- Undefined funct3 in EXECR/EXECI drives ALUControl=0000. No trap.
- instret increments by 1 (wrapping modulo 2^CNT_W) on every transition into FETCH from MEMWB, MEMWR, ALUWB or BRANCH. It never increments from reset or ERROR.

Optional Feature:
MULTICYCLE_CTRL_BLT_EN:
- Defined: BRANCH also handles funct3 100 (blt) with PCWrite = N ^ V, and 101 (bge) with PCWrite = ~(N ^ V).
- Undefined: N and V are ignored; funct3 100/101 branches are never taken but still retire.

Decomposition:
- Package multicycle_pkg:
  - state enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, JAL, BRANCH, ERROR)
  - opcode constants
  - ALUControl encodings
  - ImmSrc, ALUSrcA, ALUSrcB and ResultSrc encodings
- One sub-module, multicycle_aludec: combinational funct3/funct7b5/op[5] to ALUControl, with a force-add input and a force-sub input.

Test Plan:
- add x3,x1,x2 with mem_ready=1 throughout -> states FETCH, DECODE, EXECR, ALUWB; RegWrite=1 for exactly 1 cycle in cycle 4; ALUControl=0000 in EXECR; instret 0 -> 1.
- sw with mem_ready low for 3 cycles in MEMWR -> MemWrite=1 for 4 consecutive cycles with AdrSrc=1; one retire.
- beq with Zero=1 -> PCWrite=1 in BRANCH. bne with Zero=1 -> PCWrite=0. sub x3,x1,x2 (funct7b5=1) -> ALUControl=0001. addi with Instr[30]=1 -> ALUControl=0000.
- jal -> JAL state with PCWrite=1 then ALUWB with RegWrite=1; ImmSrc=11 throughout.
- op=7'b1111111 -> ERROR; trap=1 sticky; no enables for 20 cycles. Then reset low for 1 cycle mid-run -> FETCH, instret=0, trap=0.
- With MULTICYCLE_CTRL_BLT_EN: blt with N=1, V=0 -> PCWrite=1; bge with the same flags -> PCWrite=0. Without the macro: both give PCWrite=0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWR,
    EXECR, EXECI, ALUWB, JAL, BRANCH, ERROR
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/multicycle_aludec.sv
// Combinational ALU decoder: funct3/funct7b5/op[5] to ALUControl, with add/sub overrides.
module multicycle_aludec
  import multicycle_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  input  logic       force_add,
  input  logic       force_sub,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    if (force_sub) begin
      alu_control = ALU_SUB;
    end else if (!force_add) begin
      case (funct3)
        // Immediate forms never subtract, so op[5] qualifies the sub.
        3'b000:  alu_control = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_control = ALU_SLL;
        3'b010:  alu_control = ALU_SLT;
        3'b100:  alu_control = ALU_XOR;
        3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_control = ALU_OR;
        3'b111:  alu_control = ALU_AND;
        default: alu_control = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM with memory-ready stalls, retire counter and illegal-op trap.
// Optional blt/bge branch support: define MULTICYCLE_CTRL_BLT_EN.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             N,
  input  logic             V,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic             RegWrite,
  output logic [3:0]       ALUControl,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  logic             br_taken;
  logic             force_add, force_sub;
  logic             pc_write, ir_write, mem_write, reg_write;

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = Zero;
      3'b001:  br_taken = ~Zero;
`ifdef MULTICYCLE_CTRL_BLT_EN
      3'b100:  br_taken = N ^ V;
      3'b101:  br_taken = ~(N ^ V);
`endif
      default: br_taken = 1'b0;
    endcase
  end

`ifndef MULTICYCLE_CTRL_BLT_EN
  logic unused_flags;
  assign unused_flags = N ^ V;
`endif

  always_comb begin
    case (op)
      OP_SW:     ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      OP_JAL:    ImmSrc = IMM_J;
      default:   ImmSrc = IMM_I;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
    retire    = 1'b0;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_WD;
    force_add = 1'b1;
    force_sub = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECR;
          OP_ITYPE:     state_d = EXECI;
          OP_BRANCH:    state_d = BRANCH;
          OP_JAL:       state_d = JAL;
          default:      state_d = ERROR;
        endcase
      end
      MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_LW) ? MEMREAD : MEMWR;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      MEMWR: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      EXECR: begin
        ALUSrcA   = SRCA_A;
        force_add = 1'b0;
        state_d   = ALUWB;
      end
      EXECI: begin
        ALUSrcA   = SRCA_A;
        ALUSrcB   = SRCB_IMM;
        force_add = 1'b0;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      JAL: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        pc_write = 1'b1;
        state_d  = ALUWB;
      end
      BRANCH: begin
        ALUSrcA   = SRCA_A;
        force_sub = 1'b1;
        pc_write  = br_taken;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
    if (retire) instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  multicycle_aludec u_aludec (
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .force_add   (force_add),
    .force_sub   (force_sub),
    .alu_control (ALUControl)
  );

  // Reset lands in FETCH, whose enables follow mem_ready, so gate them with reset.
  assign PCWrite  = reset & pc_write;
  assign IRWrite  = reset & ir_write;
  assign MemWrite = reset & mem_write;
  assign RegWrite = reset & reg_write;
  assign trap     = (state_q == ERROR);
  assign instret  = instret_q;

endmodule
